// File: rtl/execute_cycle.sv
// execute_cycle -- execute stage of the 5-stage RV32 pipeline.
//
// Selects the ALU operands through the forwarding muxes, runs the ALU and
// resolves BEQ-style branches. The ALU result, store data and controls are
// registered into the E/M pipeline register that feeds memory_cycle.
//
// Optional feature (macro MUL_EN): an iterative shift-and-add multiplier
// for ALUControlE=111. While it runs, BusyE stalls the front end.
// Without MUL_EN, op 111 gives 0 and BusyE is tied low.
//
// Ports:
//   clk, rst            rising-edge clock; synchronous active-low reset
//   RegWriteE..RD_E     E-stage controls, operands, immediate and destination
//   PCE, PCPlus4E       PC and PC+4 of the E instruction
//   ForwardA_E/B_E      00/11=register file, 01=ResultW, 10=ALU_ResultM
//   ResultW             writeback-stage result
//   FlushE              squash the E instruction (a bubble goes into E/M)
//   PCSrcE, PCTargetE   branch taken, branch target (both combinational)
//   BusyE               multiplier busy; upstream holds all E inputs stable
//   *M outputs          E/M pipeline register
//   mul_state           debug view of the multiplier FSM (0 without MUL_EN)
//
// Handshake: there is no valid/ready pair. BusyE is a stall. While BusyE=1,
// upstream must present the same E inputs every cycle. During that time
// E/M loads bubbles. When BusyE drops (DONE), the still-held controls are
// registered together with the product.
module execute_cycle #(
  parameter int XLEN        = 32,
  parameter int MUL_BITS_PC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [4:0]      RD_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            BusyE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] ALU_ResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [1:0]      mul_state
);

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result, mul_result;
  logic            zero;

  // Forwarding code 10 uses the registered ALU_ResultM, which is the value
  // from before the coming edge.
  always_comb begin
    src_a = RD1_E;
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
    fwd_b = RD2_E;
    case (ForwardB_E)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
    src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
  end

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      3'b000: alu_result = src_a + src_b;
      3'b001: alu_result = src_a - src_b;
      3'b010: alu_result = src_a & src_b;
      3'b011: alu_result = src_a | src_b;
      3'b100: alu_result = src_a ^ src_b;
      3'b101: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b110: alu_result = src_a << src_b[4:0];
      default: alu_result = mul_result;
    endcase
  end

  assign zero      = (alu_result == '0);
  assign PCSrcE    = BranchE & zero & ~FlushE;
  assign PCTargetE = PCE + Imm_Ext_E;

`ifdef MUL_EN
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(XLEN / MUL_BITS_PC) + 1;
  // RUN retires all chunks but the last one. DONE retires the last chunk
  // combinationally. So BusyE lasts exactly XLEN/MUL_BITS_PC cycles,
  // counting the issue cycle.
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN / MUL_BITS_PC - 1);

  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] mul_a, mul_b, acc, partial;
  logic            mul_issue;

  assign mul_issue = (ALUControlE == 3'b111) & ~FlushE;
  assign BusyE     = rst & ((state == RUN) | ((state == IDLE) & mul_issue));
  assign mul_state = state;

  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_BITS_PC; i++)
      if (mul_b[i]) partial = partial + (mul_a << i);
  end

  assign mul_result = acc + partial;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      mul_a <= '0;
      mul_b <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: if (mul_issue) begin
          state <= RUN;
          mul_a <= src_a;
          mul_b <= src_b;
          acc   <= '0;
          count <= CNT_INIT;
        end
        RUN: if (FlushE) begin
          state <= IDLE;
        end else begin
          acc   <= mul_result;
          mul_a <= mul_a << MUL_BITS_PC;
          mul_b <= mul_b >> MUL_BITS_PC;
          count <= count - 1'b1;
          if (count == CW'(1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  localparam int unused_mul_bits = MUL_BITS_PC;
  assign mul_result = '0;
  assign BusyE      = 1'b0;
  assign mul_state  = 2'd0;
`endif

  // E/M pipeline register. Reset, flush and multiplier stall all load a
  // bubble, which zeroes the data fields too.
  always_ff @(posedge clk) begin
    if (!rst || FlushE || BusyE) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      ALU_ResultM <= '0;
      WriteDataM  <= '0;
      PCPlus4M    <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      ALU_ResultM <= alu_result;
      WriteDataM  <= fwd_b;
      PCPlus4M    <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
module tb_execute_cycle;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, FlushE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE, BusyE, RegWriteM, MemWriteM, ResultSrcM;
  logic [31:0] PCTargetE, ALU_ResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RD_M;
  logic [1:0]  mul_state;

  int checks = 0;
  int errors = 0;

  execute_cycle #(.XLEN(32), .MUL_BITS_PC(1)) dut (
    .clk(clk), .rst(rst), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .FlushE(FlushE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .mul_state(mul_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; ALUSrcE = 0;
    FlushE = 0; ALUControlE = 3'b000; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0;
    RD_E = 0; PCE = 0; PCPlus4E = 0; ForwardA_E = 0; ForwardB_E = 0; ResultW = 0;
  endtask

  task automatic test_reset();
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; BranchE = $urandom_range(0, 1);
    ALUSrcE = $urandom_range(0, 1); FlushE = 0; ALUControlE = 3'($urandom_range(0, 7));
    RD1_E = $urandom; RD2_E = $urandom; Imm_Ext_E = $urandom; RD_E = 5'($urandom_range(1, 31));
    PCE = $urandom; PCPlus4E = $urandom; ResultW = $urandom;
    ForwardA_E = 2'($urandom_range(0, 3)); ForwardB_E = 2'($urandom_range(0, 3));
    rst = 0;
    tick();
    tick();
    checks++; if (BusyE !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", BusyE); end
    checks++; if ({RegWriteM, MemWriteM, ResultSrcM} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b exp 000", {RegWriteM, MemWriteM, ResultSrcM}); end
    checks++; if (RD_M !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d exp 0", RD_M); end
    checks++; if ({ALU_ResultM, WriteDataM, PCPlus4M} !== 96'd0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", ALU_ResultM, WriteDataM, PCPlus4M); end
    checks++; if (mul_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", mul_state); end
    clear_inputs();
    rst = 1;
    tick();
  endtask

  task automatic test_add_wrap();
    clear_inputs();
    RD1_E = 32'hFFFF_FFFF; Imm_Ext_E = 32'h1; ALUSrcE = 1; ALUControlE = 3'b000;
    BranchE = 1; RegWriteE = 1; RD_E = 5'd3; PCE = 32'h100; PCPlus4E = 32'h104;
    #1;
    checks++; if (PCSrcE !== 1'b1) begin errors++; $display("FAIL add_branch_taken got %b exp 1", PCSrcE); end
    checks++; if (PCTargetE !== 32'h101) begin errors++; $display("FAIL add_target got %h exp 00000101", PCTargetE); end
    tick();
    checks++; if (ALU_ResultM !== 32'h0) begin errors++; $display("FAIL add_wrap got %h exp 00000000", ALU_ResultM); end
    checks++; if (RegWriteM !== 1'b1 || RD_M !== 5'd3) begin errors++; $display("FAIL add_ctrl got %b/%0d exp 1/3", RegWriteM, RD_M); end
    checks++; if (PCPlus4M !== 32'h104) begin errors++; $display("FAIL add_pcplus4 got %h exp 00000104", PCPlus4M); end
  endtask

  task automatic test_ops();
    logic [2:0]  op_v [8];
    logic [31:0] a_v [8];
    logic [31:0] b_v [8];
    logic [31:0] e_v [8];
    op_v = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b101, 3'b110, 3'b001, 3'b000};
    a_v  = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hAAAA5555, 32'hFFFFFFFF, 32'h5, 32'h1, 32'h0, 32'h7};
    b_v  = '{32'hFF00FF00, 32'h0F0F0000, 32'hFFFF0000, 32'h1, 32'hFFFFFFFD, 32'h3F, 32'h1, 32'h8};
    e_v  = '{32'hF000F000, 32'hFFFFF0F0, 32'h55555555, 32'h1, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'hF};
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      ALUSrcE = 1; ALUControlE = op_v[i]; RD1_E = a_v[i]; Imm_Ext_E = b_v[i]; RegWriteE = 1;
      tick();
      checks++; if (ALU_ResultM !== e_v[i]) begin errors++; $display("FAIL op_%0d got %h exp %h", i, ALU_ResultM, e_v[i]); end
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    RD1_E = 32'h10; ALUSrcE = 1; Imm_Ext_E = 0; RegWriteE = 1;
    tick();
    ForwardA_E = 2'b10; ForwardB_E = 2'b01; ResultW = 32'h5; ALUSrcE = 0;
    RD1_E = 32'h999; RD2_E = 32'h777; ALUControlE = 3'b001;
    tick();
    checks++; if (ALU_ResultM !== 32'hB) begin errors++; $display("FAIL fwd_sub got %h exp 0000000b", ALU_ResultM); end
    checks++; if (WriteDataM !== 32'h5) begin errors++; $display("FAIL fwd_wdata got %h exp 00000005", WriteDataM); end
    ForwardA_E = 2'b11; ForwardB_E = 2'b00; ALUControlE = 3'b000;
    RD1_E = 32'h20; RD2_E = 32'h3;
    tick();
    checks++; if (ALU_ResultM !== 32'h23) begin errors++; $display("FAIL fwd_11 got %h exp 00000023", ALU_ResultM); end
    checks++; if (WriteDataM !== 32'h3) begin errors++; $display("FAIL fwd_wdata_rd2 got %h exp 00000003", WriteDataM); end
  endtask

  task automatic test_flush();
    clear_inputs();
    MemWriteE = 1; RegWriteE = 1; RD_E = 5'd7; FlushE = 1; BranchE = 1;
    RD1_E = 32'h0; ALUSrcE = 1; Imm_Ext_E = 0; PCPlus4E = 32'h44;
    #1;
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL flush_pcsrc got %b exp 0", PCSrcE); end
    tick();
    checks++; if (MemWriteM !== 1'b0 || RegWriteM !== 1'b0) begin errors++; $display("FAIL flush_ctrl got %b%b exp 00", MemWriteM, RegWriteM); end
    checks++; if (RD_M !== 5'd0 || PCPlus4M !== 32'd0) begin errors++; $display("FAIL flush_bubble got %0d %h exp 0 0", RD_M, PCPlus4M); end
  endtask

  task automatic test_branch_not_taken();
    clear_inputs();
    BranchE = 1; RD1_E = 32'h5; RD2_E = 32'h4; ALUControlE = 3'b001;
    #1;
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL branch_nt got %b exp 0", PCSrcE); end
    RD2_E = 32'h5;
    #1;
    checks++; if (PCSrcE !== 1'b1) begin errors++; $display("FAIL branch_eq got %b exp 1", PCSrcE); end
    tick();
  endtask

`ifdef MUL_EN
  task automatic test_mul();
    int busy_cycles;
    int c;
    clear_inputs();
    ALUControlE = 3'b111; RD1_E = 32'h12345678; Imm_Ext_E = 32'h10; ALUSrcE = 1;
    RegWriteE = 1; RD_E = 5'd9;
    #1;
    busy_cycles = 0;
    for (c = 0; c < 100; c++) begin
      if (!BusyE) break;
      busy_cycles++;
      if (c > 0) begin
        checks++; if (RegWriteM !== 1'b0) begin errors++; $display("FAIL mul_regwrite_busy cycle %0d got %b exp 0", c, RegWriteM); end
      end
      tick();
    end
    checks++; if (c >= 100) begin errors++; $display("FAIL mul_timeout got busy>=100 exp 32"); end
    checks++; if (busy_cycles != 32) begin errors++; $display("FAIL mul_busy_len got %0d exp 32", busy_cycles); end
    tick();
    checks++; if (ALU_ResultM !== 32'h23456780) begin errors++; $display("FAIL mul_product got %h exp 23456780", ALU_ResultM); end
    checks++; if (RegWriteM !== 1'b1 || RD_M !== 5'd9) begin errors++; $display("FAIL mul_ctrl got %b/%0d exp 1/9", RegWriteM, RD_M); end
    clear_inputs();
    #1;
    checks++; if (mul_state !== 2'd0 || BusyE !== 1'b0) begin errors++; $display("FAIL mul_idle got %0d/%b exp 0/0", mul_state, BusyE); end
    tick();
  endtask

  task automatic test_mul_flush();
    clear_inputs();
    ALUControlE = 3'b111; RD1_E = 32'h3; RD2_E = 32'h4; RegWriteE = 1;
    for (int i = 0; i < 5; i++) tick();
    FlushE = 1;
    tick();
    clear_inputs();
    ALUControlE = 3'b000; RD1_E = 32'h1; RD2_E = 32'h1; RegWriteE = 1;
    #1;
    checks++; if (BusyE !== 1'b0 || mul_state !== 2'd0) begin errors++; $display("FAIL mulflush_busy got %b/%0d exp 0/0", BusyE, mul_state); end
    checks++; if (RegWriteM !== 1'b0) begin errors++; $display("FAIL mulflush_bubble got %b exp 0", RegWriteM); end
    tick();
    checks++; if (ALU_ResultM !== 32'h2) begin errors++; $display("FAIL mulflush_add got %h exp 00000002", ALU_ResultM); end
  endtask

  task automatic test_mul_reset();
    clear_inputs();
    ALUControlE = 3'b111; RD1_E = 32'h7; RD2_E = 32'h9; RegWriteE = 1; RD_E = 5'd2;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (BusyE !== 1'b1) begin errors++; $display("FAIL mulrst_running got %b exp 1", BusyE); end
    rst = 0;
    tick();
    rst = 1;
    clear_inputs();
    ALUControlE = 3'b000; RD1_E = 32'h2; Imm_Ext_E = 32'h3; ALUSrcE = 1; RegWriteE = 1; RD_E = 5'd4;
    #1;
    checks++; if (BusyE !== 1'b0 || mul_state !== 2'd0) begin errors++; $display("FAIL mulrst_busy got %b/%0d exp 0/0", BusyE, mul_state); end
    checks++; if (RegWriteM !== 1'b0 || ALU_ResultM !== 32'h0) begin errors++; $display("FAIL mulrst_outputs got %b/%h exp 0/0", RegWriteM, ALU_ResultM); end
    tick();
    checks++; if (ALU_ResultM !== 32'h5 || RegWriteM !== 1'b1 || RD_M !== 5'd4) begin errors++; $display("FAIL mulrst_add got %h/%b/%0d exp 5/1/4", ALU_ResultM, RegWriteM, RD_M); end
  endtask
`else
  task automatic test_mul_disabled();
    clear_inputs();
    ALUControlE = 3'b111; RD1_E = 32'h1234; RD2_E = 32'h10; RegWriteE = 1; RD_E = 5'd6;
    #1;
    checks++; if (BusyE !== 1'b0) begin errors++; $display("FAIL nomul_busy got %b exp 0", BusyE); end
    tick();
    checks++; if (ALU_ResultM !== 32'h0) begin errors++; $display("FAIL nomul_result got %h exp 00000000", ALU_ResultM); end
    checks++; if (RegWriteM !== 1'b1 || RD_M !== 5'd6) begin errors++; $display("FAIL nomul_ctrl got %b/%0d exp 1/6", RegWriteM, RD_M); end
  endtask
`endif

  initial begin
    rst = 0;
    clear_inputs();
    test_reset();
    test_add_wrap();
    test_ops();
    test_forwarding();
    test_flush();
    test_branch_not_taken();
`ifdef MUL_EN
    test_mul();
    test_mul_flush();
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
